add_pipe_rr_arbiter: RTL

- Shares one pipelined adder datapath (registered-input stage, fixed latency, no stall) between NUM_REQ requesters.
- Grants at most one request per cycle by round-robin and drives the datapath's operand and valid inputs.
- Carries a requester-ID tag alongside each in-flight operation and routes each result back to the requester that issued it.
- Sits between requester blocks and the shared adder pipeline wrapper; the datapath itself is external.

---
 rtl/add_pipe_rr_arbiter.sv | 110 +++++++++++
 1 files changed

// File: rtl/add_pipe_rr_arbiter.sv
// rtl/add_pipe_rr_arbiter.sv - round-robin arbiter sharing one pipelined adder among NUM_REQ requesters
// Grants one request per cycle, tags each op with its requester id and routes the result back.
module add_pipe_rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 32,
   parameter int LATENCY = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*WIDTH-1:0] req_a,
   input  logic [NUM_REQ*WIDTH-1:0] req_b,
   output logic [WIDTH-1:0]         dp_a,
   output logic [WIDTH-1:0]         dp_b,
   output logic                     dp_in_valid,
   input  logic [WIDTH-1:0]         dp_c,
   input  logic                     dp_out_valid,
   output logic [NUM_REQ-1:0]       resp_valid,
   output logic [WIDTH-1:0]         resp_data,
   output logic                     busy,
   output logic                     err
);

   localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [ID_W-1:0]    ptr_q, ptr_d;
   logic [ID_W-1:0]    gnt_id;
   logic               gnt_found;
   logic               xfer;
   logic [LATENCY-1:0] v_q;
   logic [ID_W-1:0]    id_q [LATENCY];
   logic               v_out;
   logic [ID_W-1:0]    id_out;
   logic               mismatch;
   logic               fire;
   logic               err_q, err_d;

   // Search starts at ptr and wraps; first requesting index wins.
   always_comb begin
      gnt_found = 1'b0;
      gnt_id    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         int idx;
         idx = int'(ptr_q) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!gnt_found && req_valid[idx]) begin
            gnt_found = 1'b1;
            gnt_id    = ID_W'(idx);
         end
      end
   end

   assign xfer = en & ~rst & gnt_found;

   always_comb begin
      req_ready = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_ready[i] = xfer && (gnt_id == ID_W'(i));
      end
      dp_in_valid = xfer;
      dp_a        = xfer ? req_a[int'(gnt_id)*WIDTH +: WIDTH] : '0;
      dp_b        = xfer ? req_b[int'(gnt_id)*WIDTH +: WIDTH] : '0;
   end

   always_comb begin
      ptr_d = ptr_q;
      if (xfer) begin
         ptr_d = (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;
      end
   end

   assign v_out    = v_q[LATENCY-1];
   assign id_out   = id_q[LATENCY-1];
   assign mismatch = dp_out_valid ^ v_out;
   assign fire     = dp_out_valid & v_out & ~rst;
   assign err_d    = err_q | mismatch;

   always_comb begin
      resp_valid = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         resp_valid[i] = fire && (id_out == ID_W'(i));
      end
   end

   assign resp_data = dp_c;
   assign busy      = |v_q;
   assign err       = err_q;

   // Tags shift every cycle: the datapath never stalls, so position equals age.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
         err_q <= 1'b0;
         v_q   <= '0;
         for (int s = 0; s < LATENCY; s++) id_q[s] <= '0;
      end else begin
         ptr_q   <= ptr_d;
         err_q   <= err_d;
         v_q[0]  <= xfer;
         id_q[0] <= gnt_id;
         for (int s = 1; s < LATENCY; s++) begin
            v_q[s]  <= v_q[s-1];
            id_q[s] <= id_q[s-1];
         end
      end
   end

endmodule
